// File: rtl/mire_if.sv
// -----------------------------------------------------------------------------
// wshb_if : Wishbone B4 bus bundle carrying its own clock and reset.
//
// Ports:
//   clk  input  bus clock (the only clock)
//   rst  input  synchronous, active-high reset
//
// Bundled signals:
//   cyc, stb, we, sel[3:0], cti[2:0], bte[1:0], adr[31:0], dat_ms[31:0] : master -> slave
//   ack, dat_sm[31:0]                                                  : slave -> master
//
// Handshake: a transfer completes on a rising clk edge where cyc & stb & ack
// are all 1.  While stb=1 and ack=0 the master holds adr/dat_ms/sel stable.
// -----------------------------------------------------------------------------
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;

    modport master (
        input  clk, rst, ack, dat_sm,
        output cyc, stb, we, sel, cti, bte, adr, dat_ms
    );

    modport slave (
        input  clk, rst, cyc, stb, we, sel, cti, bte, adr, dat_ms,
        output ack, dat_sm
    );
endinterface

// File: rtl/mire.sv
// -----------------------------------------------------------------------------
// mire : Wishbone write master that endlessly paints a grid test pattern into
// the SDRAM framebuffer, one 32-bit word per pixel, at the same linear byte
// addresses the VGA read stage fetches.  After every BURST completed writes
// it drops cyc for exactly one cycle so the downstream arbiter can hand the
// SDRAM port to the reader.
//
// Parameters:
//   HDISP  displayed pixels per line
//   VDISP  displayed lines per frame
//   BURST  completed writes per bus tenure (>= 1)
//
// Ports:
//   wshb_ifm   wshb_if.master  bus port; clk/rst are taken from the bundle
//   fsm_state  output [1:0]    current FSM state (0 IDLE, 1 WRITE, 2 PAUSE)
//
// Handshake: a write completes on a rising clk edge where cyc & stb & ack are
// all 1.  adr/dat_ms depend only on the pixel counters, so they hold stable
// while stb=1 and ack=0.  ack seen outside WRITE is ignored.
// -----------------------------------------------------------------------------
module mire #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int BURST = 64
) (
    wshb_if.master     wshb_ifm,
    output logic [1:0] fsm_state
);
    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          req;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [BW-1:0] bcnt;
    logic          advance;
    logic          last_beat;
    logic          x_last;
    logic          y_last;
    logic [31:0]   x32;
    logic [31:0]   y32;
    logic [31:0]   pix;

    assign advance   = (state == WRITE) && wshb_ifm.ack;
    assign last_beat = (bcnt == BW'(BURST - 1));
    assign x_last    = (x == XW'(HDISP - 1));
    assign y_last    = (y == YW'(VDISP - 1));

    // State register
    always_ff @(posedge wshb_ifm.clk) begin
        if (wshb_ifm.rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and bus request
    always_comb begin
        state_nx = state;
        req      = 1'b0;
        unique case (state)
            IDLE: begin
                state_nx = WRITE;
            end
            WRITE: begin
                req = 1'b1;
                if (wshb_ifm.ack && last_beat) begin
                    state_nx = PAUSE;
                end
            end
            PAUSE: begin
                state_nx = WRITE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Pixel and burst counters move only on a completed write.
    always_ff @(posedge wshb_ifm.clk) begin
        if (wshb_ifm.rst) begin
            x    <= '0;
            y    <= '0;
            bcnt <= '0;
        end else if (advance) begin
            bcnt <= last_beat ? '0 : bcnt + BW'(1);
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // Widen first so the grid test on bits [3:0] is legal even when a
    // counter is narrower than 4 bits.
    assign x32 = 32'(x);
    assign y32 = 32'(y);
    assign pix = 32'(HDISP) * y32 + x32;

    assign wshb_ifm.cyc    = req;
    assign wshb_ifm.stb    = req;
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.sel    = 4'hF;
    assign wshb_ifm.cti    = 3'd0;
    assign wshb_ifm.bte    = 2'd0;
    assign wshb_ifm.adr    = {pix[29:0], 2'b00};
    assign wshb_ifm.dat_ms = ((x32[3:0] == 4'd0) || (y32[3:0] == 4'd0)) ? 32'h00FF_FFFF
                                                                        : 32'h0000_0000;

    assign fsm_state = state;
endmodule

// File: tb/tb_mire.sv
module tb_mire;
  localparam int HDISP = 32;
  localparam int VDISP = 4;
  localparam int BURST = 5;
  localparam int NPIX  = HDISP * VDISP;
  localparam int QFILL = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wshb_if wb (.clk(clk), .rst(rst));
  logic [1:0] fsm_state;

  mire #(.HDISP(HDISP), .VDISP(VDISP), .BURST(BURST)) dut (
    .wshb_ifm  (wb),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];          // {adr, dat} of each expected write, in order
  int checks = 0;
  int errors = 0;
  int hs_total = 0;
  int hs_since_reset = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the write stream is simply pixel p = 0,1,2,... wrapping
  // every frame; address is 4*p, the pixel is white on every 16th column/row.
  task automatic fill_expected();
    int p;
    int px;
    int py;
    logic [31:0] a;
    logic [31:0] d;
    exp_q.delete();
    p = 0;
    for (int i = 0; i < QFILL; i++) begin
      px = p % HDISP;
      py = p / HDISP;
      a  = 32'(4 * p);
      d  = ((px % 16) == 0 || (py % 16) == 0) ? 32'h00FF_FFFF : 32'h0;
      exp_q.push_back({a, d});
      p  = (p + 1) % NPIX;
    end
  endtask

  // ---------------- driver ----------------
  int ack_mode = 0;   // 0: ack always 1, 1: random ack, 2: slave with 3 wait states
  int wcnt = 0;

  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0: wb.ack = 1'b1;
      1: wb.ack = ($urandom_range(0, 2) == 0);
      default: begin
        if (wb.stb) begin
          if (wcnt == 3) begin
            wb.ack = 1'b1;
            wcnt = 0;
          end else begin
            wb.ack = 1'b0;
            wcnt++;
          end
        end else begin
          // spurious acks while the master is idle or paused
          wb.ack = ($urandom_range(0, 1) == 1);
        end
      end
    endcase
  end

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    fill_expected();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  bit          rst_prev = 1'b0;
  bit          prev_valid = 1'b0;
  bit          prev_stb = 1'b0;
  bit          prev_ack = 1'b0;
  logic [31:0] prev_adr;
  logic [31:0] prev_dat;
  int          tenure = 0;
  int          gap = 0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      if (rst_prev) begin
        chk("reset_cyc", 32'(wb.cyc), 32'd0);
        chk("reset_stb", 32'(wb.stb), 32'd0);
        chk("reset_adr", wb.adr, 32'd0);
        chk("reset_dat", wb.dat_ms, 32'h00FF_FFFF);
      end
      tenure = 0;
      gap = 0;
      prev_valid = 1'b0;
      prev_stb = 1'b0;
      hs_since_reset = 0;
    end else begin
      if (wb.cyc !== wb.stb) chk("cyc_stb_equal", 32'(wb.cyc), 32'(wb.stb));
      if (wb.stb) begin
        if (!prev_stb) begin
          chk("idle_gap_len", 32'(gap), 32'd1);
          gap = 0;
        end
        if (prev_valid && prev_stb && !prev_ack) begin
          chk("hold_adr", wb.adr, prev_adr);
          chk("hold_dat", wb.dat_ms, prev_dat);
        end
        if (wb.ack === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("queue_underflow", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("write_adr", wb.adr, e[63:32]);
            chk("write_dat", wb.dat_ms, e[31:0]);
          end
          chk("tied_we_sel", {27'd0, wb.we, wb.sel}, {27'd0, 1'b1, 4'hF});
          chk("tied_cti_bte", {27'd0, wb.cti, wb.bte}, 32'd0);
          tenure++;
          hs_total++;
          hs_since_reset++;
        end
      end else begin
        if (prev_stb) begin
          chk("burst_len", 32'(tenure), 32'(BURST));
          tenure = 0;
        end
        gap++;
      end
      prev_stb = wb.stb;
      prev_ack = wb.ack;
      prev_adr = wb.adr;
      prev_dat = wb.dat_ms;
      prev_valid = 1'b1;
    end
    rst_prev = rst;
  end

  // ---------------- sequence ----------------
  initial begin
    int start;
    bit hit;
    wb.ack = 1'b0;
    wb.dat_sm = 32'h0;
    fill_expected();

    // Zero-wait slave: full frames, wrap with bursts straddling it.
    ack_mode = 0;
    do_reset(3);
    start = hs_total;
    repeat (320) @(posedge clk);
    chk("zero_wait_progress", 32'(hs_total - start >= 2 * NPIX), 32'd1);

    // Random ack, then reset in the middle of a burst after the 7th write.
    ack_mode = 1;
    do_reset(2);
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (hs_since_reset == 7 && wb.stb) hit = 1'b1;
    end
    chk("reach_mid_burst", 32'(hit), 32'd1);
    ack_mode = 0;
    do_reset(2);
    start = hs_total;
    repeat (40) @(posedge clk);
    chk("restart_progress", 32'(hs_total - start >= 3 * BURST), 32'd1);

    // Random ack (spurious acks while idle/paused included).
    ack_mode = 1;
    start = hs_total;
    repeat (800) @(posedge clk);
    chk("random_progress", 32'(hs_total - start > 100), 32'd1);

    // Slave with three wait states per transfer; crosses a frame wrap.
    ack_mode = 2;
    start = hs_total;
    repeat (700) @(posedge clk);
    chk("wait_state_progress", 32'(hs_total - start > 120), 32'd1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
